data_mem_master: RTL and testbench

Sequential initiator for the combinational data memory: it accepts single or burst load/store requests from the datapath over a valid/ready handshake and drives the memory's address, write-data and write-strobe inputs one word per cycle. It captures the combinational read data into registers, streams store data from an upstream source, and converts the memory's out-of-range exception into a terminated transaction with an error status. It sits between the execute/LSU stage and the data memory.

---
 rtl/data_mem_master.sv | 154 +++++++++++++++
 tb/tb_data_mem_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_master.sv
// data_mem_master: sequential initiator for a combinational data memory.
// Accepts single/burst load/store requests and issues one word per cycle.
// It registers the load data and streams the store data straight through.
// A memory exception ends the transaction with an error status.
// Optional feature macro: DMM_BOUNDS_CHECK_EN adds a local out-of-range check on
// cur_addr. That check also blocks the write strobe regardless of the memory.
module data_mem_master #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned LEN_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request channel
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  // store data source
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_pop_o,
  // load data / completion
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  // memory side
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_write_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_exception_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [ADDR_WIDTH:0] MemSizeW = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_e                state_q;
  logic                  ready_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [LEN_WIDTH-1:0]  beats_left_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  done_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  logic in_access;
  logic oor;
  logic fault;
  logic store_go;
  logic load_go;

  assign in_access = (state_q == StAccess);
  assign oor       = ({1'b0, cur_addr_q} >= MemSizeW);

`ifdef DMM_BOUNDS_CHECK_EN
  assign fault = in_access & (mem_exception_i | oor);
`else
  assign fault = in_access & mem_exception_i;

  // Without the local check we rely on the memory to flag every out-of-range access.
  a_mem_flags_oor: assert property (@(posedge clk) disable iff (!rst_n)
                                    (in_access && oor) |-> mem_exception_i);
`endif

  // A store beat only fires with data available; a faulting beat never fires.
  assign store_go = in_access & write_q & wr_valid_i & ~fault;
  assign load_go  = in_access & ~write_q & ~fault;

  // Memory-side drive: only from registered state and current inputs, so reset kills it at once.
  always_comb begin
    mem_addr_o  = cur_addr_q;
    mem_write_o = store_go;
    wr_pop_o    = store_go;
    mem_wdata_o = (in_access && write_q) ? wr_data_i : '0;
  end

  assign req_ready_o = ready_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;

  // Control FSM with registered handshake, status and load-data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      write_q      <= 1'b0;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      // done/err/rd_valid are single-cycle pulses
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && ready_q) begin
            write_q      <= req_write_i;
            cur_addr_q   <= req_addr_i;
            beats_left_q <= req_len_i;
            ready_q      <= 1'b0;
            state_q      <= StAccess;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StAccess: begin
          if (fault) begin
            err_addr_q <= cur_addr_q;
            err_q      <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= StResp;
          end else if (store_go || load_go) begin
            if (load_go) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= mem_rdata_i;
            end
            if (beats_left_q == '0) begin
              done_q  <= 1'b1;
              state_q <= StResp;
            end else begin
              cur_addr_q   <= cur_addr_q + ADDR_WIDTH'(1);
              beats_left_q <= beats_left_q - LEN_WIDTH'(1);
            end
          end
        end
        StResp: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_master.sv
// Bench for data_mem_master: table of load/store transactions with a read-data
// scoreboard, plus hand-written reset sequences.
module tb_data_mem_master;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MS = 1024;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_pop;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
  logic          mem_exception;

  always #5 clk = ~clk;

  data_mem_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE  (MS),
    .LEN_WIDTH (LW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_addr_i     (req_addr),
    .req_len_i      (req_len),
    .wr_valid_i     (wr_valid),
    .wr_data_i      (wr_data),
    .wr_pop_o       (wr_pop),
    .rd_valid_o     (rd_valid),
    .rd_data_o      (rd_data),
    .done_o         (done),
    .err_o          (err),
    .err_addr_o     (err_addr),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_write_o    (mem_write),
    .mem_rdata_i    (mem_rdata),
    .mem_exception_i(mem_exception)
  );

  // Combinational data memory with out-of-range exception
  logic [DW-1:0] mem     [MS];
  logic [DW-1:0] ref_mem [MS];

  assign mem_exception = (32'(mem_addr) >= MS);
  assign mem_rdata     = mem_exception ? '0 : mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_write && !mem_exception) mem[mem_addr[9:0]] <= mem_wdata;
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [DW-1:0] base;
    int            stall_beat;
    int            stall_n;
    logic          exp_err;
    logic [AW-1:0] exp_eaddr;
    int            exp_pops;
    int            exp_rds;
    int            exp_done;   // cycles from accept to done, accept cycle counted as 1
  } vec_t;

  vec_t          vecs [8];
  int            n_vec  = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < MS; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic wait_ready(input string name);
    int c = 0;
    while (!req_ready && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(name, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int            beat = 0;
    int            stalls = 0;
    int            pops = 0;
    int            rds = 0;
    int            c = 0;
    bit            seen_done = 1'b0;
    logic [AW-1:0] a;
    // model: beats run until the first out-of-range address
    for (int i = 0; i <= int'(v.len); i++) begin
      a = v.addr + AW'(i);
      if (32'(a) >= MS) break;
      if (v.wr) ref_mem[a[9:0]] = v.base + DW'(i);
      else sb.push_back(ref_mem[a[9:0]]);
    end
    wait_ready($sformatf("ready v%0d", idx));
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_len   = v.len;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    while (!seen_done && c < 40) begin
      if (v.wr && beat == v.stall_beat && stalls < v.stall_n) begin
        wr_valid = 1'b0;
        stalls++;
      end else begin
        wr_valid = v.wr;
      end
      wr_data = v.base + DW'(beat);
      #1;
      if (wr_pop) begin
        pops++;
        beat++;
      end
      @(posedge clk);
      c++;
      #1;
      if (rd_valid) begin
        rds++;
        if (sb.size() == 0) check($sformatf("rd_extra v%0d", idx), 32'd1, 32'd0);
        else check($sformatf("rd_data v%0d", idx), 32'(rd_data), 32'(sb.pop_front()));
      end
      if (done) begin
        seen_done = 1'b1;
        check($sformatf("done_cyc v%0d", idx), 32'(c + 1), 32'(v.exp_done));
        check($sformatf("err v%0d", idx), {31'd0, err}, {31'd0, v.exp_err});
        if (v.exp_err) check($sformatf("err_addr v%0d", idx), 32'(err_addr), 32'(v.exp_eaddr));
      end
    end
    wr_valid = 1'b0;
    check($sformatf("done_seen v%0d", idx), {31'd0, seen_done}, 32'd1);
    check($sformatf("pops v%0d", idx), 32'(pops), 32'(v.exp_pops));
    check($sformatf("rds v%0d", idx), 32'(rds), 32'(v.exp_rds));
    check($sformatf("sb_left v%0d", idx), 32'(sb.size()), 32'd0);
    sb.delete();
    if (v.wr) check_mem($sformatf("memimg v%0d", idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    for (int i = 0; i < MS; i++) begin
      mem[i]     = DW'(16'h5000 + i);
      ref_mem[i] = DW'(16'h5000 + i);
    end
    mem[5]     = 16'h1234;
    ref_mem[5] = 16'h1234;

    // wr, addr, len, base, stall_beat, stall_n, err, err_addr, pops, rds, done
    vecs[0] = '{1'b0, 16'd5,     3'd0, 16'h0,  -1, 0, 1'b0, 16'h0,    0, 1, 2};
    vecs[1] = '{1'b1, 16'd10,    3'd3, 16'hA0,  2, 2, 1'b0, 16'h0,    4, 0, 7};
    vecs[2] = '{1'b0, 16'd10,    3'd3, 16'h0,  -1, 0, 1'b0, 16'h0,    0, 4, 5};
    vecs[3] = '{1'b0, 16'd1020,  3'd7, 16'h0,  -1, 0, 1'b1, 16'd1024, 0, 4, 6};
    vecs[4] = '{1'b1, 16'hFFFF,  3'd1, 16'hE0, -1, 0, 1'b1, 16'hFFFF, 0, 0, 2};
    vecs[5] = '{1'b1, 16'd1022,  3'd3, 16'hB0, -1, 0, 1'b1, 16'd1024, 2, 0, 4};
    vecs[6] = '{1'b0, 16'd1022,  3'd1, 16'h0,  -1, 0, 1'b0, 16'h0,    0, 2, 3};
    vecs[7] = '{1'b1, 16'd1023,  3'd1, 16'hD0,  1, 3, 1'b1, 16'd1024, 1, 0, 3};

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_flags", {27'd0, rd_valid, done, err, mem_write, wr_pop}, 32'd0);
    check("rst_rd_eaddr", {rd_data, err_addr}, 32'd0);
    check("rst_maddr_wdata", {mem_addr, mem_wdata}, 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset during beat 2 of a 6-beat store to 100..105
    wait_ready("ready rst_mid");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'd100;
    req_len   = 3'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wr_valid  = 1'b1;
    for (int b = 0; b < 2; b++) begin
      wr_data = 16'hC0 + DW'(b);
      @(posedge clk);
      #1;
    end
    wr_data = 16'hC2;
    #1;
    check("mid_mw_before", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_mw_after", {31'd0, mem_write}, 32'd0);
    check("mid_pop_done", {30'd0, wr_pop, done}, 32'd0);
    check("mid_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
      if (k == 0) check("mid_ready_rel", {31'd0, req_ready}, 32'd1);
    end
    check("mid_no_done", 32'(seen), 32'd0);
    ref_mem[100] = 16'hC0;
    ref_mem[101] = 16'hC1;
    check_mem("memimg rst_mid");

    // Unit still works after the aborted transaction
    run_vec(8, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
